// File: rtl/spm_scratchpad.sv
// spm_scratchpad: dual-port scratchpad data memory on the core's load/store path.
// One byte-enabled word store and one word load can be issued per clock.
// The load data is registered, so it appears one cycle after the request.
//
// Ports:
//   clk                clock; all state updates on the rising edge
//   rst_n              asynchronous active-low reset; clears only the load data register
//   spm_rdaddress      byte address of the load; bits [1:0] and the bits above the index are ignored
//   spm_rden           load request
//   spm_rd_data        registered load data
//   spm_wraddress      byte address of the store; decoded the same way as the load address
//   spm_wren           store request
//   spm_write_data     store data; byte lane k is bits 8k+7:8k
//   spm_store_byteena  per-lane store enable; bit k enables lane k
module spm_scratchpad #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int IDX_WIDTH  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             spm_rdaddress,
  input  logic                    spm_rden,
  output logic [DATA_WIDTH-1:0]   spm_rd_data,
  input  logic [31:0]             spm_wraddress,
  input  logic                    spm_wren,
  input  logic [DATA_WIDTH-1:0]   spm_write_data,
  input  logic [DATA_WIDTH/8-1:0] spm_store_byteena
);

  localparam int NB = DATA_WIDTH / 8;

  // Replace the enabled byte lanes of old_word with the lanes of new_word.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_WIDTH-1:0]  rd_idx_p0;
  logic [IDX_WIDTH-1:0]  wr_idx_p0;
  logic [DATA_WIDTH-1:0] wr_word_p0;
  logic [DATA_WIDTH-1:0] rd_word_p0;
  logic [DATA_WIDTH-1:0] rd_data_p1;

  // Address bits outside the word index only select byte-in-word or alias; they are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{spm_rdaddress[31:IDX_WIDTH+2], spm_rdaddress[1:0],
                              spm_wraddress[31:IDX_WIDTH+2], spm_wraddress[1:0]};

  assign rd_idx_p0  = spm_rdaddress[IDX_WIDTH+1:2];
  assign wr_idx_p0  = spm_wraddress[IDX_WIDTH+1:2];
  assign wr_word_p0 = lane_merge(mem[wr_idx_p0], spm_write_data, spm_store_byteena);

  // Write-first bypass: a load hitting the word being stored sees the merged word.
  always_comb begin
    rd_word_p0 = mem[rd_idx_p0];
    if (spm_wren && (wr_idx_p0 == rd_idx_p0)) begin
      rd_word_p0 = lane_merge(mem[rd_idx_p0], spm_write_data, spm_store_byteena);
    end
  end

  // ---- stage p0 -> p1: array write and load data register ----
  // A store on an edge where reset is held is discarded; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && spm_wren) begin
      mem[wr_idx_p0] <= wr_word_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
    end else if (spm_rden) begin
      rd_data_p1 <= rd_word_p0;
    end
  end

  assign spm_rd_data = rd_data_p1;

endmodule

// File: tb/tb_spm_scratchpad.sv
module tb_spm_scratchpad;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] spm_rdaddress;
  logic        spm_rden;
  logic [31:0] spm_rd_data;
  logic [31:0] spm_wraddress;
  logic        spm_wren;
  logic [31:0] spm_write_data;
  logic [3:0]  spm_store_byteena;

  int total = 0;
  int bad   = 0;

  spm_scratchpad dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .spm_rdaddress     (spm_rdaddress),
    .spm_rden          (spm_rden),
    .spm_rd_data       (spm_rd_data),
    .spm_wraddress     (spm_wraddress),
    .spm_wren          (spm_wren),
    .spm_write_data    (spm_write_data),
    .spm_store_byteena (spm_store_byteena)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed sparse memory; a word is known only once all four bytes are written.
  logic [7:0]  model_b [int];
  logic [31:0] exp_rd    = 32'h0;
  bit          exp_known = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_rd    = 32'h0;
      exp_known = 1'b1;
    end else begin
      int wbase;
      int rbase;
      wbase = int'((spm_wraddress % 32'd16384) & ~32'd3);
      rbase = int'((spm_rdaddress % 32'd16384) & ~32'd3);
      if (spm_wren) begin
        for (int k = 0; k < 4; k++)
          if (spm_store_byteena[k]) model_b[wbase + k] = spm_write_data[8*k +: 8];
      end
      if (spm_rden) begin
        exp_known = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (model_b.exists(rbase + k)) exp_rd[8*k +: 8] = model_b[rbase + k];
          else exp_known = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (exp_known) check("model_cmp", spm_rd_data, exp_rd);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    spm_wren = en; spm_wraddress = a; spm_write_data = d; spm_store_byteena = be;
  endtask

  task automatic set_rd(input logic en, input logic [31:0] a);
    spm_rden = en; spm_rdaddress = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h100);
    repeat (3) cyc();
    check("reset_rd", spm_rd_data, 32'h0);

    rst_n = 1'b1;
    set_rd(1'b1, 32'h300);
    cyc();

    // full word store then load
    set_rd(1'b0, 32'h0);
    set_wr(1'b1, 32'h100, 32'h12345678, 4'hF);
    cyc();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h100);
    cyc();
    check("full_word", spm_rd_data, 32'h12345678);

    // byte lanes
    set_rd(1'b0, 32'h100);
    set_wr(1'b1, 32'h100, 32'hAABBCCDD, 4'b0101);
    cyc();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h100);
    cyc();
    check("byte_lanes", spm_rd_data, 32'h12BB56DD);
    set_rd(1'b0, 32'h0);
    set_wr(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000);
    cyc();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h100);
    cyc();
    check("be_zero", spm_rd_data, 32'h12BB56DD);

    // read-during-write, same word
    set_rd(1'b0, 32'h0);
    set_wr(1'b1, 32'h200, 32'h11111111, 4'hF);
    cyc();
    set_wr(1'b1, 32'h200, 32'hFFFFFFFF, 4'b1100);
    set_rd(1'b1, 32'h200);
    cyc();
    check("rdw_same", spm_rd_data, 32'hFFFF1111);

    // wren low ignores byteena; differing indices do not interact
    set_wr(1'b0, 32'h200, 32'h00000000, 4'hF);
    set_rd(1'b1, 32'h200);
    cyc();
    check("wren_off", spm_rd_data, 32'hFFFF1111);
    set_wr(1'b1, 32'h100, 32'h55555555, 4'hF);
    set_rd(1'b1, 32'h200);
    cyc();
    check("rdw_diff", spm_rd_data, 32'hFFFF1111);
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h100);
    cyc();
    check("rdw_diff_wr", spm_rd_data, 32'h55555555);

    // aliasing and hold
    set_rd(1'b0, 32'h0);
    set_wr(1'b1, 32'h4, 32'hCAFEBABE, 4'hF);
    cyc();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h7);
    cyc();
    check("alias_low", spm_rd_data, 32'hCAFEBABE);
    set_rd(1'b1, 32'h100);
    cyc();
    check("between", spm_rd_data, 32'h55555555);
    set_rd(1'b1, 32'h4004);
    cyc();
    check("alias_wrap", spm_rd_data, 32'hCAFEBABE);
    set_rd(1'b0, 32'h100);
    cyc();
    cyc();
    check("hold", spm_rd_data, 32'hCAFEBABE);

    // reset mid-operation with a store pending during reset
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", spm_rd_data, 32'h0);
    set_wr(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    set_rd(1'b1, 32'h4);
    cyc();
    check("rst_held", spm_rd_data, 32'h0);
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b0, 32'h4);
    rst_n = 1'b1;
    cyc();
    check("post_rst_idle", spm_rd_data, 32'h0);
    set_rd(1'b1, 32'h4);
    cyc();
    check("mem_kept", spm_rd_data, 32'hCAFEBABE);
    set_rd(1'b0, 32'h0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
